// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write/read bus of the 2-read 1-write register file.
//   master : drives WE, WADDR, WDATA, WSTRB, RADDR_A, RADDR_B; receives RDATA_A/B
//   slave  : the register file side
// The register file has no handshake. Writes commit on the clock edge, and reads
// are combinational.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
);
  logic               WE;
  logic [AW-1:0]      WADDR;
  logic [WIDTH-1:0]   WDATA;
  logic [WIDTH/8-1:0] WSTRB;
  logic [AW-1:0]      RADDR_A;
  logic [AW-1:0]      RADDR_B;
  logic [WIDTH-1:0]   RDATA_A;
  logic [WIDTH-1:0]   RDATA_B;

  modport master (
    output WE, WADDR, WDATA, WSTRB, RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B
  );

  modport slave (
    input  WE, WADDR, WDATA, WSTRB, RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised register file with one write port and two read ports.
// This is the integer register file between decode and execute.
//   CLK     : clock; all state changes on the rising edge
//   RST     : synchronous active-high reset; loads RESET_VAL (entry 0 gets 0 if ZERO_REG)
//   bus     : slave side of reg_file_2r1w_if
//             WE/WADDR/WDATA/WSTRB is the byte-strobed write port
//             RADDR_A/RDATA_A and RADDR_B/RDATA_B are the zero-latency read ports
// Optional features:
//   ZERO_REG : entry 0 is hardwired to zero
//   BYPASS   : a same-cycle write is forwarded to the read data
module reg_file_2r1w #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               AW        = $clog2(DEPTH),
  parameter bit               ZERO_REG  = 1'b1,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             CLK,
  input logic             RST,
  reg_file_2r1w_if.slave  bus
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // When DEPTH is not a power of two, an AW-bit address can point past the array.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_entry(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [LANES-1:0] strb
  );
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // A write is effective only outside reset, in range, and not aimed at the zero entry.
  // The same qualifier gates bypass, so the forwarded value always matches what the
  // entry will hold after the edge.
  assign wr_ok = bus.WE && !RST && in_range(bus.WADDR) && !is_zero_entry(bus.WADDR);

  always_comb begin
    wr_old   = '0;
    stored_a = '0;
    stored_b = '0;
    if (in_range(bus.WADDR))   wr_old   = mem[bus.WADDR];
    if (in_range(bus.RADDR_A)) stored_a = mem[bus.RADDR_A];
    if (in_range(bus.RADDR_B)) stored_b = mem[bus.RADDR_B];
  end

  assign wr_merged = merge_lanes(wr_old, bus.WDATA, bus.WSTRB);

  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    a,
    input logic [WIDTH-1:0] stored
  );
    if (!in_range(a) || is_zero_entry(a)) return '0;
    if (BYPASS && wr_ok && (a == bus.WADDR)) return wr_merged;
    return stored;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
      end
    end else if (wr_ok) begin
      mem[bus.WADDR] <= wr_merged;
    end
  end

  assign bus.RDATA_A = read_port(bus.RADDR_A, stored_a);
  assign bus.RDATA_B = read_port(bus.RADDR_B, stored_b);

endmodule
